// File: rtl/dispatch_steer_if.sv
// Dispatch-side bundle: fetch queue pop, jump redirect, issue-queue writes, tag return.
// No state; master modport is the dispatcher, slave modport is fetch/issue/commit side.
// Optional stats outputs exist only when DISPATCH_STATS_EN is defined.
interface dispatch_steer_if #(
    parameter int NUM_INT = 2,
    parameter int TAG_W   = 5,
    parameter int PC_W    = 32
);
    logic [PC_W-1:0]    ifetch_pc_4;
    logic [31:0]        ifetch_intruction;
    logic               ifetch_empty;
    logic               Dispatch_ren;
    logic               Dispatch_jmp;
    logic [PC_W-1:0]    Dispatch_jmp_addr;
    logic [NUM_INT-1:0] issueque_integer_full;
    logic               issueque_mul_full;
    logic               issueque_full_ld_st;
    logic [NUM_INT-1:0] dispatch_en_integer;
    logic               dispatch_en_mul;
    logic               dispatch_en_ld_st;
    logic [3:0]         dispatch_opcode;
    logic [4:0]         dispatch_rs_addr;
    logic [4:0]         dispatch_rt_addr;
    logic [TAG_W-1:0]   dispatch_rd_tag;
    logic [4:0]         dispatch_shfamt;
    logic [15:0]        dispatch_imm_ld_st;
    logic               commit_tag_free;
`ifdef DISPATCH_STATS_EN
    logic [31:0]        stat_dispatched;
    logic [31:0]        stat_stall_cycles;
`endif

    modport master (
        input  ifetch_pc_4, ifetch_intruction, ifetch_empty,
        input  issueque_integer_full, issueque_mul_full, issueque_full_ld_st,
        input  commit_tag_free,
        output Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr,
        output dispatch_en_integer, dispatch_en_mul, dispatch_en_ld_st,
        output dispatch_opcode, dispatch_rs_addr, dispatch_rt_addr,
        output dispatch_rd_tag, dispatch_shfamt, dispatch_imm_ld_st
`ifdef DISPATCH_STATS_EN
        , output stat_dispatched, stat_stall_cycles
`endif
    );

    modport slave (
        output ifetch_pc_4, ifetch_intruction, ifetch_empty,
        output issueque_integer_full, issueque_mul_full, issueque_full_ld_st,
        output commit_tag_free,
        input  Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr,
        input  dispatch_en_integer, dispatch_en_mul, dispatch_en_ld_st,
        input  dispatch_opcode, dispatch_rs_addr, dispatch_rt_addr,
        input  dispatch_rd_tag, dispatch_shfamt, dispatch_imm_ld_st
`ifdef DISPATCH_STATS_EN
        , input stat_dispatched, stat_stall_cycles
`endif
    );
endinterface

// File: rtl/dispatch_steer.sv
// Decode/dispatch: one instr per cycle, tag allocation, round-robin INT steering, J flush.
// Latency: queue writes, fields, tag and jump pulse are registered, one cycle after the fetch pop.
// Backpressure: holds the instruction while its target is full or the tag pool is empty; DISPATCH_STATS_EN adds counters.
module dispatch_steer #(
    parameter int NUM_INT = 2,
    parameter int TAG_W   = 5,
    parameter int PC_W    = 32
) (
    input  logic            clock,
    input  logic            reset,
    dispatch_steer_if.master bus
);
    localparam int RR_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
    localparam logic [RR_W:0]  NUM_INT_W = (RR_W+1)'(NUM_INT);
    localparam logic [TAG_W:0] POOL_SIZE = {1'b1, {TAG_W{1'b0}}};

    localparam logic [3:0] OPC_ADD = 4'd1;
    localparam logic [3:0] OPC_SUB = 4'd2;
    localparam logic [3:0] OPC_AND = 4'd3;
    localparam logic [3:0] OPC_OR  = 4'd4;
    localparam logic [3:0] OPC_SLT = 4'd5;
    localparam logic [3:0] OPC_SLL = 4'd6;
    localparam logic [3:0] OPC_SRL = 4'd7;
    localparam logic [3:0] OPC_MUL = 4'd8;
    localparam logic [3:0] OPC_LW  = 4'd9;
    localparam logic [3:0] OPC_SW  = 4'd10;
    localparam logic [3:0] OPC_BEQ = 4'd11;

    typedef enum logic {S_RUN, S_FLUSH} state_t;
    typedef enum logic [2:0] {C_NOP, C_INT, C_MUL, C_LDST, C_JMP} cls_t;

    state_t             state_q, state_d;
    logic [RR_W-1:0]    rr_q, rr_d;
    logic [TAG_W-1:0]   next_tag_q, next_tag_d;
    logic [TAG_W:0]     free_cnt_q, free_cnt_d;
    logic [NUM_INT-1:0] en_int_q, en_int_d;
    logic               en_mul_q, en_mul_d;
    logic               en_ldst_q, en_ldst_d;
    logic [3:0]         opcode_q, opcode_d;
    logic [4:0]         rs_q, rs_d;
    logic [4:0]         rt_q, rt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [4:0]         sh_q, sh_d;
    logic [15:0]        imm_q, imm_d;
    logic               jmp_q, jmp_d;
    logic [PC_W-1:0]    jaddr_q, jaddr_d;

    logic [31:0]        instr;
    cls_t               cls;
    logic [3:0]         opc;
    logic               need_tag;
    logic               target_ok;
    logic               accept;
    logic               dispatch;
    logic               jmp_take;
    logic               tag_ret;
    logic               pc_lo_unused;

    logic [NUM_INT-1:0] full_rot;
    logic               int_found;
    logic [RR_W-1:0]    int_off;
    logic [RR_W:0]      int_sum;
    logic [RR_W-1:0]    int_sel;
    logic [RR_W:0]      rr_inc;

    assign instr        = bus.ifetch_intruction;
    assign pc_lo_unused = ^bus.ifetch_pc_4[27:0];

    always_comb begin
        cls = C_NOP;
        opc = 4'd0;
        if (instr != 32'd0) begin
            unique case (instr[31:26])
                6'h00: begin
                    unique case (instr[5:0])
                        6'h20:   begin cls = C_INT; opc = OPC_ADD; end
                        6'h22:   begin cls = C_INT; opc = OPC_SUB; end
                        6'h24:   begin cls = C_INT; opc = OPC_AND; end
                        6'h25:   begin cls = C_INT; opc = OPC_OR;  end
                        6'h2A:   begin cls = C_INT; opc = OPC_SLT; end
                        6'h00:   begin cls = C_INT; opc = OPC_SLL; end
                        6'h02:   begin cls = C_INT; opc = OPC_SRL; end
                        6'h18:   begin cls = C_MUL; opc = OPC_MUL; end
                        default: begin cls = C_NOP; opc = 4'd0;    end
                    endcase
                end
                6'h23:   begin cls = C_LDST; opc = OPC_LW;  end
                6'h2B:   begin cls = C_LDST; opc = OPC_SW;  end
                6'h04:   begin cls = C_INT;  opc = OPC_BEQ; end
                6'h02:   begin cls = C_JMP;  opc = 4'd0;    end
                default: begin cls = C_NOP;  opc = 4'd0;    end
            endcase
        end
    end

    // Rotate the full mask so bit 0 is rr_q, pick the lowest free slot, then rotate back.
    always_comb begin
        full_rot  = NUM_INT'({bus.issueque_integer_full, bus.issueque_integer_full} >> rr_q);
        int_found = 1'b0;
        int_off   = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (!full_rot[i]) begin
                int_found = 1'b1;
                int_off   = RR_W'(i);
            end
        end
        int_sum = {1'b0, rr_q} + {1'b0, int_off};
        if (int_sum >= NUM_INT_W) begin
            int_sum = int_sum - NUM_INT_W;
        end
        int_sel = int_sum[RR_W-1:0];
        rr_inc  = {1'b0, int_sel} + (RR_W+1)'(1);
        if (rr_inc >= NUM_INT_W) begin
            rr_inc = '0;
        end
    end

    always_comb begin
        need_tag  = (cls == C_INT) || (cls == C_MUL) || (cls == C_LDST);
        target_ok = 1'b1;
        unique case (cls)
            C_INT:   target_ok = int_found;
            C_MUL:   target_ok = !bus.issueque_mul_full;
            C_LDST:  target_ok = !bus.issueque_full_ld_st;
            default: target_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        bus.Dispatch_ren = 1'b0;
        unique case (state_q)
            S_RUN: begin
                accept = !bus.ifetch_empty && target_ok &&
                         (!need_tag || (free_cnt_q != '0));
                bus.Dispatch_ren = accept;
                if (accept && (cls == C_JMP)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // The instruction behind a taken jump is on the wrong path: drop it.
                bus.Dispatch_ren = !bus.ifetch_empty;
                state_d          = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign dispatch = accept && need_tag;
    assign jmp_take = accept && (cls == C_JMP);
    // A return while the pool is full is spurious unless a tag leaves in the same cycle.
    assign tag_ret  = bus.commit_tag_free && ((free_cnt_q != POOL_SIZE) || dispatch);

    always_comb begin
        rr_d       = rr_q;
        next_tag_d = next_tag_q;
        free_cnt_d = free_cnt_q;
        en_int_d   = '0;
        en_mul_d   = 1'b0;
        en_ldst_d  = 1'b0;
        opcode_d   = opcode_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        tag_d      = tag_q;
        sh_d       = sh_q;
        imm_d      = imm_q;
        jmp_d      = jmp_take;
        jaddr_d    = jaddr_q;

        if (dispatch) begin
            next_tag_d = next_tag_q + TAG_W'(1);
            opcode_d   = opc;
            rs_d       = instr[25:21];
            rt_d       = instr[20:16];
            sh_d       = instr[10:6];
            imm_d      = instr[15:0];
            tag_d      = next_tag_q;
            unique case (cls)
                C_INT: begin
                    en_int_d = NUM_INT'(1) << int_sel;
                    rr_d     = rr_inc[RR_W-1:0];
                end
                C_MUL:   en_mul_d  = 1'b1;
                default: en_ldst_d = 1'b1;
            endcase
        end

        unique case ({dispatch, tag_ret})
            2'b10:   free_cnt_d = free_cnt_q - (TAG_W+1)'(1);
            2'b01:   free_cnt_d = free_cnt_q + (TAG_W+1)'(1);
            default: free_cnt_d = free_cnt_q;
        endcase

        if (jmp_take) begin
            jaddr_d = {bus.ifetch_pc_4[PC_W-1:28], instr[25:0], 2'b00};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_RUN;
            rr_q       <= '0;
            next_tag_q <= '0;
            free_cnt_q <= POOL_SIZE;
            en_int_q   <= '0;
            en_mul_q   <= 1'b0;
            en_ldst_q  <= 1'b0;
            opcode_q   <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            tag_q      <= '0;
            sh_q       <= '0;
            imm_q      <= '0;
            jmp_q      <= 1'b0;
            jaddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            next_tag_q <= next_tag_d;
            free_cnt_q <= free_cnt_d;
            en_int_q   <= en_int_d;
            en_mul_q   <= en_mul_d;
            en_ldst_q  <= en_ldst_d;
            opcode_q   <= opcode_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            tag_q      <= tag_d;
            sh_q       <= sh_d;
            imm_q      <= imm_d;
            jmp_q      <= jmp_d;
            jaddr_q    <= jaddr_d;
        end
    end

    assign bus.Dispatch_jmp        = jmp_q;
    assign bus.Dispatch_jmp_addr   = jaddr_q;
    assign bus.dispatch_en_integer = en_int_q;
    assign bus.dispatch_en_mul     = en_mul_q;
    assign bus.dispatch_en_ld_st   = en_ldst_q;
    assign bus.dispatch_opcode     = opcode_q;
    assign bus.dispatch_rs_addr    = rs_q;
    assign bus.dispatch_rt_addr    = rt_q;
    assign bus.dispatch_rd_tag     = tag_q;
    assign bus.dispatch_shfamt     = sh_q;
    assign bus.dispatch_imm_ld_st  = imm_q;

`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_disp_q, stat_disp_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_disp_d  = stat_disp_q;
        stat_stall_d = stat_stall_q;
        if (dispatch) begin
            stat_disp_d = stat_disp_q + 32'd1;
        end
        if (!bus.ifetch_empty && (state_q == S_RUN) && !accept) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_disp_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_disp_q  <= stat_disp_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign bus.stat_dispatched   = stat_disp_q;
    assign bus.stat_stall_cycles = stat_stall_q;
`endif
endmodule

// File: tb/tb_dispatch_steer.sv
// Table-driven bench for dispatch_steer with a one-deep expected-result queue.
module tb_dispatch_steer;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    dispatch_steer_if #(.NUM_INT(2), .TAG_W(5), .PC_W(32)) ifc ();

    dispatch_steer #(.NUM_INT(2), .TAG_W(5), .PC_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        empty;
        logic [1:0]  ifull;
        logic        mfull;
        logic        lfull;
        logic        commit;
        logic        ren;
        logic [1:0]  ei;
        logic        em;
        logic        el;
        logic [3:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [4:0]  tag;
        logic        jmp;
        logic [31:0] ja;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk_add(input logic [4:0] tag, input logic [1:0] ei, input logic ren,
                                    input logic [1:0] ifull, input logic commit);
        vec_t v;
        v = '{32'h00000020, 32'h0, 1'b0, ifull, 1'b0, 1'b0, commit, ren, ei, 1'b0, 1'b0,
              4'd1, 5'd0, 5'd0, 5'd0, 16'h0020, tag, 1'b0, 32'h0};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ifc.ifetch_intruction     = v.instr;
        ifc.ifetch_pc_4           = v.pc4;
        ifc.ifetch_empty          = v.empty;
        ifc.issueque_integer_full = v.ifull;
        ifc.issueque_mul_full     = v.mfull;
        ifc.issueque_full_ld_st   = v.lfull;
        ifc.commit_tag_free       = v.commit;
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clock);
        drive(v);
        #1;
        chk("ren", 32'(ifc.Dispatch_ren), 32'(v.ren));
        sb.push_back(v);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("en_integer", 32'(ifc.dispatch_en_integer), 32'(e.ei));
        chk("en_mul", 32'(ifc.dispatch_en_mul), 32'(e.em));
        chk("en_ld_st", 32'(ifc.dispatch_en_ld_st), 32'(e.el));
        chk("jmp", 32'(ifc.Dispatch_jmp), 32'(e.jmp));
        if (e.jmp) begin
            chk("jmp_addr", ifc.Dispatch_jmp_addr, e.ja);
        end
        if ((e.ei != 2'b00) || e.em || e.el) begin
            chk("opcode", 32'(ifc.dispatch_opcode), 32'(e.opc));
            chk("rs", 32'(ifc.dispatch_rs_addr), 32'(e.rs));
            chk("rt", 32'(ifc.dispatch_rt_addr), 32'(e.rt));
            chk("shamt", 32'(ifc.dispatch_shfamt), 32'(e.sh));
            chk("imm", 32'(ifc.dispatch_imm_ld_st), 32'(e.imm));
            chk("rd_tag", 32'(ifc.dispatch_rd_tag), 32'(e.tag));
        end
    endtask

    task automatic do_reset(input logic [1:0] ifull);
        @(negedge clock);
        reset = 1'b1;
        ifc.ifetch_intruction     = 32'h00000020;
        ifc.ifetch_empty          = 1'b0;
        ifc.issueque_integer_full = ifull;
        ifc.commit_tag_free       = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_en_integer", 32'(ifc.dispatch_en_integer), 32'h0);
        chk("rst_en_mul", 32'(ifc.dispatch_en_mul), 32'h0);
        chk("rst_en_ld_st", 32'(ifc.dispatch_en_ld_st), 32'h0);
        chk("rst_jmp", 32'(ifc.Dispatch_jmp), 32'h0);
        chk("rst_jmp_addr", ifc.Dispatch_jmp_addr, 32'h0);
        chk("rst_rd_tag", 32'(ifc.dispatch_rd_tag), 32'h0);
        chk("rst_opcode", 32'(ifc.dispatch_opcode), 32'h0);
        chk("rst_imm", 32'(ifc.dispatch_imm_ld_st), 32'h0);
`ifdef DISPATCH_STATS_EN
        chk("rst_stat_dispatched", ifc.stat_dispatched, 32'h0);
        chk("rst_stat_stall", ifc.stat_stall_cycles, 32'h0);
`endif
        @(negedge clock);
        reset = 1'b0;
        ifc.ifetch_empty = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ifc.ifetch_intruction     = 32'h0;
        ifc.ifetch_pc_4           = 32'h0;
        ifc.ifetch_empty          = 1'b1;
        ifc.issueque_integer_full = 2'b00;
        ifc.issueque_mul_full     = 1'b0;
        ifc.issueque_full_ld_st   = 1'b0;
        ifc.commit_tag_free       = 1'b0;

        //            instr         pc4           emp   ifull  mf    lf    cm    ren   ei     em    el    opc    rs     rt     sh     imm        tag    jmp   ja
        tbl[0]  = '{32'h0080F820, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'd1,  5'd4,  5'd0,  5'd0,  16'hF820, 5'd0,  1'b0, 32'h0};
        tbl[1]  = '{32'h00BF1018, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 4'd8,  5'd5,  5'd31, 5'd0,  16'h1018, 5'd1,  1'b0, 32'h0};
        tbl[2]  = '{32'h00000020, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd1,  5'd0,  5'd0,  5'd0,  16'h0020, 5'd2,  1'b0, 32'h0};
        tbl[3]  = '{32'h00000020, 32'h0,        1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd1,  5'd0,  5'd0,  5'd0,  16'h0020, 5'd3,  1'b0, 32'h0};
        tbl[4]  = '{32'h8C850008, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'd9,  5'd4,  5'd5,  5'd0,  16'h0008, 5'd4,  1'b0, 32'h0};
        tbl[5]  = '{32'hAC850004, 32'h0,        1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 5'd0,  1'b0, 32'h0};
        tbl[6]  = '{32'hAC850004, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'd10, 5'd4,  5'd5,  5'd0,  16'h0004, 5'd5,  1'b0, 32'h0};
        tbl[7]  = '{32'h10850003, 32'h0,        1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 5'd0,  1'b0, 32'h0};
        tbl[8]  = '{32'h10850003, 32'h0,        1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 5'd0,  1'b0, 32'h0};
        tbl[9]  = '{32'h10850003, 32'h0,        1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'd11, 5'd4,  5'd5,  5'd0,  16'h0003, 5'd6,  1'b0, 32'h0};
        tbl[10] = '{32'h00052080, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd6,  5'd0,  5'd5,  5'd2,  16'h2080, 5'd7,  1'b0, 32'h0};
        tbl[11] = '{32'hFC000000, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 5'd0,  1'b0, 32'h0};
        tbl[12] = '{32'h00000000, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 5'd0,  1'b0, 32'h0};
        tbl[13] = '{32'h00000020, 32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 5'd0,  1'b0, 32'h0};
        tbl[14] = '{32'h00BF1018, 32'h0,        1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 5'd0,  1'b0, 32'h0};
        tbl[15] = '{32'h00BF1018, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 4'd8,  5'd5,  5'd31, 5'd0,  16'h1018, 5'd8,  1'b0, 32'h0};
        tbl[16] = '{32'h08000010, 32'h00400004, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 5'd0,  1'b1, 32'h00000040};
        tbl[17] = '{32'h00000020, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 5'd0,  1'b0, 32'h0};
        tbl[18] = '{32'h00000020, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'd1,  5'd0,  5'd0,  5'd0,  16'h0020, 5'd9,  1'b0, 32'h0};

        repeat (2) @(posedge clock);
        #1;
        chk("reset_en_integer", 32'(ifc.dispatch_en_integer), 32'h0);
        chk("reset_en_mul", 32'(ifc.dispatch_en_mul), 32'h0);
        chk("reset_en_ld_st", 32'(ifc.dispatch_en_ld_st), 32'h0);
        chk("reset_jmp", 32'(ifc.Dispatch_jmp), 32'h0);
        chk("reset_rd_tag", 32'(ifc.dispatch_rd_tag), 32'h0);
        chk("reset_opcode", 32'(ifc.dispatch_opcode), 32'h0);
        chk("reset_ren_empty", 32'(ifc.Dispatch_ren), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i]);
        end
`ifdef DISPATCH_STATS_EN
        chk("stat_dispatched", ifc.stat_dispatched, 32'd10);
        chk("stat_stall_cycles", ifc.stat_stall_cycles, 32'd4);
`endif

        // Reset while the jump flush is pending: next instruction must dispatch normally.
        step(tbl[16]);
        do_reset(2'b00);
        step(mk_add(5'd0, 2'b01, 1'b1, 2'b00, 1'b0));
        step(mk_add(5'd1, 2'b10, 1'b1, 2'b00, 1'b0));
        step(mk_add(5'd2, 2'b01, 1'b1, 2'b00, 1'b0));

        // Reset in the middle of an all-full stall, then drain the whole pool.
        step(mk_add(5'd0, 2'b00, 1'b0, 2'b11, 1'b0));
        do_reset(2'b11);
        for (int i = 0; i < 32; i++) begin
            step(mk_add(5'(i), ((i % 2) == 0) ? 2'b01 : 2'b10, 1'b1, 2'b00, 1'b0));
        end
        step(mk_add(5'd0, 2'b00, 1'b0, 2'b00, 1'b0));
        step(mk_add(5'd0, 2'b00, 1'b0, 2'b00, 1'b1));
        step(mk_add(5'd0, 2'b01, 1'b1, 2'b00, 1'b0));
        step(mk_add(5'd0, 2'b00, 1'b0, 2'b00, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
